// File: rtl/leaf_pkg.sv
// ---------------------------------------------------------------------------
// leaf_pkg
// Shared definitions for the leaf output arbiter: packet field widths, the
// bit offset of every field inside a packet, the output-register state
// type and a helper that assembles a valid packet from its fields.
//
// Packet layout, MSB first: {valid, dest_leaf, dest_port, addr, payload}
// ---------------------------------------------------------------------------
package leaf_pkg;

    localparam int LEAF_BITS = 5;
    localparam int PORT_BITS = 4;
    localparam int ADDR_BITS = 7;
    localparam int DATA_BITS = 32;
    localparam int PKT_BITS  = 1 + LEAF_BITS + PORT_BITS + ADDR_BITS + DATA_BITS;

    // Field offsets (LSB position of each field)
    localparam int DATA_LSB  = 0;
    localparam int ADDR_LSB  = DATA_LSB + DATA_BITS;
    localparam int PORT_LSB  = ADDR_LSB + ADDR_BITS;
    localparam int LEAF_LSB  = PORT_LSB + PORT_BITS;
    localparam int VALID_BIT = LEAF_LSB + LEAF_BITS;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Build a packet with the valid bit set.
    function automatic logic [PKT_BITS-1:0] pack_packet(
        input logic [LEAF_BITS-1:0] leaf,
        input logic [PORT_BITS-1:0] port,
        input logic [ADDR_BITS-1:0] addr,
        input logic [DATA_BITS-1:0] data
    );
        logic [PKT_BITS-1:0] pkt;
        pkt                         = '0;
        pkt[VALID_BIT]              = 1'b1;
        pkt[LEAF_LSB +: LEAF_BITS]  = leaf;
        pkt[PORT_LSB +: PORT_BITS]  = port;
        pkt[ADDR_LSB +: ADDR_BITS]  = addr;
        pkt[DATA_LSB +: DATA_BITS]  = data;
        return pkt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Returns a one-hot grant for the first
// requester found when searching upward from ptr+1, wrapping WIDTH-1 -> 0.
//
// Ports
//   req   in  WIDTH     request vector
//   ptr   in  PTR_BITS  index of the previous winner
//   grant out WIDTH     one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int WIDTH    = 4,
    parameter int PTR_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]    req,
    input  logic [PTR_BITS-1:0] ptr,
    output logic [WIDTH-1:0]    grant
);

    logic [WIDTH-1:0] upper_mask;
    logic [WIDTH-1:0] masked_req;
    logic [WIDTH-1:0] pick_src;

    // Bits strictly above ptr. When ptr is the top index the shift
    // overflows to zero and the mask collapses to empty, forcing the wrap.
    assign upper_mask = ~((WIDTH'(2) << ptr) - WIDTH'(1));
    assign masked_req = req & upper_mask;

    // Requests above the pointer take priority; otherwise wrap to the bottom.
    assign pick_src   = (|masked_req) ? masked_req : req;

    // Isolate the lowest set bit.
    assign grant      = pick_src & (~pick_src + WIDTH'(1));

endmodule

// File: rtl/leaf_out_arbiter.sv
// ---------------------------------------------------------------------------
// leaf_out_arbiter
// Merges NUM_OUT_PORTS user payload streams into a single packet stream.
// Each port has a configurable destination, an enable, a credit counter
// (returned by the destination) and a sequence counter used as the packet
// address. One round-robin grant per cycle loads a one-deep output register.
//
// Ports
//   clk            in   1                          clock
//   reset_n        in   1                          async active-low reset
//   din_user2arb   in   NUM_OUT_PORTS*PAYLOAD_BITS payloads, port 0 at LSBs
//   vld_user2arb   in   NUM_OUT_PORTS              payload valid per port
//   ack_arb2user   out  NUM_OUT_PORTS              one-cycle accept pulse
//   cfg_we         in   1                          destination-table write
//   cfg_port       in   3                          port being configured
//   cfg_dest       in   LEAF+PORT bits             {dest_leaf, dest_port}
//   cfg_en         in   1                          port enable
//   credit_vld     in   1                          credit return strobe
//   credit_port    in   3                          port receiving credit
//   credit_amt     in   NUM_ADDR_BITS+1            credits returned
//   dout_arb2bft   out  PACKET_BITS                packet, MSB = valid
//   rdy_bft2arb    in   1                          downstream accepts packet
// ---------------------------------------------------------------------------
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 4,
    parameter int PAYLOAD_BITS  = DATA_BITS,
    parameter int NUM_LEAF_BITS = LEAF_BITS,
    parameter int NUM_PORT_BITS = PORT_BITS,
    parameter int NUM_ADDR_BITS = ADDR_BITS,
    parameter int PACKET_BITS   = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS,
    parameter int CREDIT_MAX    = 128
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user2arb,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2arb,
    output logic [NUM_OUT_PORTS-1:0]                ack_arb2user,
    input  logic                                    cfg_we,
    input  logic [2:0]                              cfg_port,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
    input  logic                                    cfg_en,
    input  logic                                    credit_vld,
    input  logic [2:0]                              credit_port,
    input  logic [NUM_ADDR_BITS:0]                  credit_amt,
    output logic [PACKET_BITS-1:0]                  dout_arb2bft,
    input  logic                                    rdy_bft2arb
);

    localparam int PTR_BITS    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam int CREDIT_BITS = $clog2(CREDIT_MAX + 1);
    localparam int DEST_BITS   = NUM_LEAF_BITS + NUM_PORT_BITS;
    // Wide enough to hold credit + credit_amt before saturation.
    localparam int SUM_BITS    = ((CREDIT_BITS > NUM_ADDR_BITS + 1) ? CREDIT_BITS : NUM_ADDR_BITS + 1) + 1;

    out_state_t                 state_reg, state_next;
    logic [PACKET_BITS-1:0]     dout_reg, dout_next;
    logic [PTR_BITS-1:0]        last_grant_reg, last_grant_next;

    logic [CREDIT_BITS-1:0]     credit_reg [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0]   addr_reg   [NUM_OUT_PORTS];
    logic [DEST_BITS-1:0]       dest_reg   [NUM_OUT_PORTS];
    logic                       enable_reg [NUM_OUT_PORTS];

    logic [NUM_OUT_PORTS-1:0]   eligible;
    logic [NUM_OUT_PORTS-1:0]   req_masked;
    logic [NUM_OUT_PORTS-1:0]   grant_onehot;
    logic                       grant_valid;
    logic                       can_grant;

    logic [PTR_BITS-1:0]        grant_idx;
    logic [PAYLOAD_BITS-1:0]    sel_payload;
    logic [DEST_BITS-1:0]       sel_dest;
    logic [NUM_ADDR_BITS-1:0]   sel_addr;

    // A new packet may be loaded when the register is empty or is being
    // drained this very cycle.
    assign can_grant  = (state_reg == ST_EMPTY) || rdy_bft2arb;
    assign req_masked = eligible & {NUM_OUT_PORTS{can_grant}};

    rr_arbiter #(
        .WIDTH    (NUM_OUT_PORTS),
        .PTR_BITS (PTR_BITS)
    ) u_rr_arbiter (
        .req   (req_masked),
        .ptr   (last_grant_reg),
        .grant (grant_onehot)
    );

    assign grant_valid  = |grant_onehot;
    assign ack_arb2user = grant_onehot;
    assign dout_arb2bft = dout_reg;

    // Mux the winning port's fields.
    always_comb begin
        grant_idx   = '0;
        sel_payload = '0;
        sel_dest    = '0;
        sel_addr    = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant_onehot[i]) begin
                grant_idx   = PTR_BITS'(i);
                sel_payload = din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                sel_dest    = dest_reg[i];
                sel_addr    = addr_reg[i];
            end
        end
    end

    // Per-port bookkeeping: eligibility, credits, sequence and config.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
            logic                   credit_hit;
            logic                   cfg_hit;
            logic [SUM_BITS-1:0]    credit_sum;
            logic [CREDIT_BITS-1:0] credit_next;

            // Out-of-range port numbers never match any gi, so they are dropped.
            assign credit_hit = credit_vld && (int'(credit_port) == gi);
            assign cfg_hit    = cfg_we && (int'(cfg_port) == gi);

            assign eligible[gi] = vld_user2arb[gi] & enable_reg[gi] & (credit_reg[gi] != '0);

            // A grant implies credit >= 1, so the subtraction cannot underflow.
            assign credit_sum  = SUM_BITS'(credit_reg[gi])
                               + (credit_hit ? SUM_BITS'(credit_amt) : SUM_BITS'(0))
                               - SUM_BITS'(grant_onehot[gi]);
            assign credit_next = (credit_sum > SUM_BITS'(CREDIT_MAX)) ? CREDIT_BITS'(CREDIT_MAX)
                                                                       : credit_sum[CREDIT_BITS-1:0];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    credit_reg[gi] <= CREDIT_BITS'(CREDIT_MAX);
                    addr_reg[gi]   <= '0;
                    dest_reg[gi]   <= '0;
                    enable_reg[gi] <= 1'b0;
                end else begin
                    credit_reg[gi] <= credit_next;
                    if (grant_onehot[gi]) begin
                        addr_reg[gi] <= addr_reg[gi] + 1'b1;
                    end
                    if (cfg_hit) begin
                        dest_reg[gi]   <= cfg_dest;
                        enable_reg[gi] <= cfg_en;
                    end
                end
            end
        end
    endgenerate

    // Output register FSM: next state and next packet.
    always_comb begin
        state_next      = state_reg;
        dout_next       = dout_reg;
        last_grant_next = last_grant_reg;
        if (grant_valid) begin
            state_next      = ST_FULL;
            dout_next       = pack_packet(sel_dest[DEST_BITS-1 -: NUM_LEAF_BITS],
                                          sel_dest[NUM_PORT_BITS-1:0],
                                          sel_addr,
                                          sel_payload);
            last_grant_next = grant_idx;
        end else if ((state_reg == ST_FULL) && rdy_bft2arb) begin
            state_next = ST_EMPTY;
            dout_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_EMPTY;
            dout_reg       <= '0;
            last_grant_reg <= PTR_BITS'(NUM_OUT_PORTS - 1);
        end else begin
            state_reg      <= state_next;
            dout_reg       <= dout_next;
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// ---------------------------------------------------------------------------
// tb_leaf_out_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a behavioural model of the arbiter; directed phases additionally
// pin hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_leaf_out_arbiter;

    localparam int N    = 4;
    localparam int PW   = 32;
    localparam int CMAX = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N*PW-1:0] din;
    logic [N-1:0]    vld;
    logic [N-1:0]    ack;
    logic            cfg_we;
    logic [2:0]      cfg_port;
    logic [8:0]      cfg_dest;
    logic            cfg_en;
    logic            credit_vld;
    logic [2:0]      credit_port;
    logic [7:0]      credit_amt;
    logic [48:0]     dout;
    logic            rdy;

    always #5 clk = ~clk;

    leaf_out_arbiter #(
        .NUM_OUT_PORTS (N),
        .CREDIT_MAX    (CMAX)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .din_user2arb (din),
        .vld_user2arb (vld),
        .ack_arb2user (ack),
        .cfg_we       (cfg_we),
        .cfg_port     (cfg_port),
        .cfg_dest     (cfg_dest),
        .cfg_en       (cfg_en),
        .credit_vld   (credit_vld),
        .credit_port  (credit_port),
        .credit_amt   (credit_amt),
        .dout_arb2bft (dout),
        .rdy_bft2arb  (rdy)
    );

    // ---------------- behavioural model ----------------
    int          m_credit [N];
    int          m_addr   [N];
    int          m_leaf   [N];
    int          m_port   [N];
    bit          m_en     [N];
    int          m_last;
    bit          m_full;
    logic [63:0] m_out;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [N-1:0] obs_ack;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_credit[i] = CMAX;
            m_addr[i]   = 0;
            m_leaf[i]   = 0;
            m_port[i]   = 0;
            m_en[i]     = 1'b0;
        end
        m_last = N - 1;
        m_full = 1'b0;
        m_out  = 64'd0;
    endtask

    // Port that wins this cycle, or -1.
    function automatic int model_grant();
        if (m_full && !rdy) return -1;
        for (int k = 1; k <= N; k++) begin
            int p;
            p = (m_last + k) % N;
            if (vld[p] && m_en[p] && m_credit[p] > 0) return p;
        end
        return -1;
    endfunction

    function automatic logic [63:0] model_pkt(input int leaf, input int port, input int addr,
                                              input logic [31:0] data);
        return (64'd1 << 48) | (64'(leaf) << 43) | (64'(port) << 39) | (64'(addr) << 32) | 64'(data);
    endfunction

    task automatic model_update(input int g);
        if (g >= 0) begin
            m_out     = model_pkt(m_leaf[g], m_port[g], m_addr[g], din[g*PW +: PW]);
            m_full    = 1'b1;
            m_last    = g;
            m_addr[g] = (m_addr[g] + 1) % 128;
        end else if (m_full && rdy) begin
            m_out  = 64'd0;
            m_full = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            int c;
            c = m_credit[i];
            if (g == i) c = c - 1;
            if (credit_vld && int'(credit_port) == i) c = c + int'(credit_amt);
            if (c > CMAX) c = CMAX;
            m_credit[i] = c;
        end
        if (cfg_we && int'(cfg_port) < N) begin
            m_leaf[cfg_port] = int'(cfg_dest) >> 4;
            m_port[cfg_port] = int'(cfg_dest) & 15;
            m_en[cfg_port]   = cfg_en;
        end
    endtask

    // One clock cycle: inputs already driven after the falling edge.
    task automatic cycle();
        int g;
        #1;
        g = reset_n ? model_grant() : -1;
        chk("ack", 64'(ack), (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("dout", 64'(dout), m_out);
        obs_ack = ack;
        if (g >= 0)
            $display("cyc %0d grant port %0d addr %0d payload %h", cyc, g, m_addr[g], din[g*PW +: PW]);
        @(posedge clk);
        if (reset_n) model_update(g);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_dout_immediate", 64'(dout), 64'd0);
        chk("rst_ack_immediate", 64'(ack), 64'd0);
        vld        = '0;
        cfg_we     = 1'b0;
        credit_vld = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic cfg(input int p, input int leaf, input int port, input bit en);
        cfg_we   = 1'b1;
        cfg_port = 3'(p);
        cfg_dest = {5'(leaf), 4'(port)};
        cfg_en   = en;
        cycle();
        cfg_we   = 1'b0;
    endtask

    logic [48:0] exp_pkt;
    logic [48:0] held;
    int          n;

    initial begin
        reset_n     = 1'b0;
        din         = '0;
        vld         = '0;
        cfg_we      = 1'b0;
        cfg_port    = '0;
        cfg_dest    = '0;
        cfg_en      = 1'b0;
        credit_vld  = 1'b0;
        credit_port = '0;
        credit_amt  = '0;
        rdy         = 1'b1;
        model_reset();
        @(negedge clk);
        chk("reset_dout", 64'(dout), 64'd0);
        chk("reset_ack", 64'(ack), 64'd0);

        // Streaming on port 0 with address wrap past 127.
        do_reset();
        cfg(0, 3, 2, 1'b1);
        din[31:0]   = 32'hDEADBEEF;
        vld         = 4'b0001;
        rdy         = 1'b1;
        credit_vld  = 1'b1;
        credit_port = 3'd0;
        credit_amt  = 8'd1;
        cycle();
        chk("a_first_ack", 64'(obs_ack), 64'd1);
        for (int k = 1; k <= 130; k++) begin
            exp_pkt = {1'b1, 5'd3, 4'd2, 7'((k - 1) % 128), 32'hDEADBEEF};
            chk("a_pkt", 64'(dout), 64'(exp_pkt));
            cycle();
            chk("a_ack", 64'(obs_ack), 64'd1);
        end

        // Round robin across all four ports.
        do_reset();
        for (int p = 0; p < N; p++) cfg(p, p + 1, p + 4, 1'b1);
        for (int p = 0; p < N; p++) din[p*PW +: PW] = $urandom();
        vld = 4'b1111;
        rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("b_rr_order", 64'(obs_ack), 64'd1 << (k % 4));
        end
        cycle();
        chk("b_credits_exhausted", 64'(obs_ack), 64'd0);

        // Credit exhaustion and return on port 1.
        do_reset();
        cfg(1, 7, 1, 1'b1);
        vld = 4'b0010;
        n   = 0;
        repeat (6) begin
            cycle();
            n += $countones(obs_ack);
        end
        chk("c_acks_before_stall", 64'(n), 64'(CMAX));
        credit_vld  = 1'b1;
        credit_port = 3'd1;
        credit_amt  = 8'd1;
        cycle();
        n += $countones(obs_ack);
        credit_vld = 1'b0;
        repeat (5) begin
            cycle();
            n += $countones(obs_ack);
        end
        chk("c_one_more_ack", 64'(n), 64'(CMAX + 1));

        // Back-pressure hold then same-cycle drain and refill.
        do_reset();
        cfg(2, 9, 3, 1'b1);
        din[2*PW +: PW] = $urandom();
        vld         = 4'b0100;
        rdy         = 1'b1;
        credit_vld  = 1'b1;
        credit_port = 3'd2;
        credit_amt  = 8'd1;
        cycle();
        rdy  = 1'b0;
        held = dout;
        n    = 0;
        repeat (5) begin
            cycle();
            chk("d_hold_stable", 64'(dout), 64'(held));
            n += $countones(obs_ack);
        end
        chk("d_no_ack_while_full", 64'(n), 64'd0);
        chk("d_held_valid", 64'(held[48]), 64'd1);
        rdy = 1'b1;
        cycle();
        chk("d_refill_ack", 64'(obs_ack), 64'b0100);
        chk("d_next_addr", 64'(dout), 64'(held) + (64'd1 << 32));

        // Reset while FULL with a grant otherwise pending, then credit restore.
        do_reset();
        cfg(0, 1, 1, 1'b1);
        vld = 4'b0001;
        n   = 0;
        repeat (6) begin
            cycle();
            n += $countones(obs_ack);
        end
        chk("e_credit_restored", 64'(n), 64'(CMAX));

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if (c == 2500) do_reset();
            vld = 4'($urandom());
            for (int p = 0; p < N; p++) din[p*PW +: PW] = $urandom();
            rdy         = ($urandom_range(0, 3) != 0);
            cfg_we      = ($urandom_range(0, 19) == 0);
            cfg_port    = 3'($urandom_range(0, 7));
            cfg_dest    = 9'($urandom());
            cfg_en      = ($urandom_range(0, 6) != 0);
            credit_vld  = ($urandom_range(0, 9) < 6);
            credit_port = ($urandom_range(0, 9) == 0) ? 3'd6 : 3'($urandom_range(0, 3));
            credit_amt  = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : 8'($urandom_range(0, 3));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
